// File: rtl/alu_exec_seq.sv
// Execute-stage sequencer for the 8-bit ALU: reads operands from a small register file,
// drives the ALU, captures result/flags and writes back, one instruction per four cycles.
module alu_exec_seq #(
    parameter int NREGS = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [$clog2(NREGS)-1:0] in_rs,
    input  logic [$clog2(NREGS)-1:0] in_rt,
    input  logic [WIDTH-1:0]         in_imm,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_func,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_zero,
    input  logic                     alu_sign,
    input  logic                     alu_ovf,
    output logic                     done,
    output logic [WIDTH-1:0]         done_result,
    output logic                     err,
    output logic                     flag_z,
    output logic                     flag_s,
    output logic                     flag_v,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int AW = $clog2(NREGS);

    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LI  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t state;

    logic [3:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rs_q;
    logic [AW-1:0]    rt_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             sign_q;
    logic             ovf_q;

    logic [WIDTH-1:0] regs [NREGS];

    logic             op_is_alu;
    logic             op_is_li;
    logic             op_legal;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;

    assign op_is_alu = (op_q <= OP_XOR);
    assign op_is_li  = (op_q == OP_LI);
    assign op_legal  = op_is_alu || op_is_li;
    assign in_ready  = (state == S_IDLE);

    // r0 always reads as zero regardless of what the array holds.
    always_comb begin
        rs_data  = (rs_q == '0) ? '0 : regs[rs_q];
        rt_data  = (rt_q == '0) ? '0 : regs[rt_q];
        dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            imm_q       <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_func    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            done_result <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= in_op;
                        rd_q  <= in_rd;
                        rs_q  <= in_rs;
                        rt_q  <= in_rt;
                        imm_q <= in_imm;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    alu_a    <= rs_data;
                    alu_b    <= rt_data;
                    alu_func <= op_is_alu ? op_q : 4'd0;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    res_q  <= op_is_li ? imm_q : alu_result;
                    zero_q <= alu_zero;
                    sign_q <= alu_sign;
                    ovf_q  <= alu_ovf;
                    done   <= 1'b1;
                    err    <= !op_legal;
                    // Illegal ops report zero so a stray ALU value never leaks out.
                    if (!op_legal)
                        done_result <= '0;
                    else if (op_is_li)
                        done_result <= imm_q;
                    else
                        done_result <= alu_result;
                    state <= S_WB;
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Writeback happens on the WB->IDLE edge so a dependent instruction's READ sees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            flag_z <= 1'b0;
            flag_s <= 1'b0;
            flag_v <= 1'b0;
        end else if (state == S_WB) begin
            if (op_legal && (rd_q != '0))
                regs[rd_q] <= res_q;
            if (op_is_alu) begin
                flag_z <= zero_q;
                flag_s <= sign_q;
                flag_v <= ovf_q;
            end
        end
    end

endmodule
